// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone arbiter: FSM encoding, CTI codes,
// default widths and a small index helper.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_e;

    // Wishbone cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int DEF_NUM_MASTERS = 2;
    localparam int DEF_DATA        = 32;
    localparam int DEF_ADDR        = 32;
    localparam int DEF_TIMEOUT     = 255;

    // Next index after idx, wrapping to 0 past n-1
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the requesting masters, the arbiter and the shared slave.
// The arbiter uses the slave modport (it serves the masters); the environment
// that drives requests and slave responses uses the master modport.
interface wb_arbiter_if import wb_pkg::*; #(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int DATA        = DEF_DATA,
    parameter int ADDR        = DEF_ADDR
);
    localparam int STRB = DATA / 8;

    logic [NUM_MASTERS-1:0]      m_cyc_i, m_stb_i, m_we_i;
    logic [NUM_MASTERS*ADDR-1:0] m_adr_i;
    logic [NUM_MASTERS*DATA-1:0] m_dat_i;
    logic [NUM_MASTERS*STRB-1:0] m_sel_i;
    logic [NUM_MASTERS-1:0]      m_ack_o, m_err_o;
    logic [DATA-1:0]             m_dat_o;

    logic                        s_cyc_o, s_stb_o, s_we_o;
    logic [ADDR-1:0]             s_adr_o;
    logic [DATA-1:0]             s_dat_o;
    logic [STRB-1:0]             s_sel_o;
    logic                        s_ack_i, s_err_i;
    logic [DATA-1:0]             s_dat_i;

    logic [NUM_MASTERS-1:0]      grant_o;
    logic [15:0]                 timeout_cnt_o;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        input  s_ack_i, s_err_i, s_dat_i,
        output m_ack_o, m_err_o, m_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        output grant_o, timeout_cnt_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        output s_ack_i, s_err_i, s_dat_i,
        input  m_ack_o, m_err_o, m_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        input  grant_o, timeout_cnt_o
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first request at or after the pointer.
module rr_pick import wb_pkg::*; #(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int PTR_W       = 1
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [PTR_W-1:0]       i_ptr,
    output logic [NUM_MASTERS-1:0] o_gnt
);
    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    // Walk the requesters starting at the pointer; first hit wins
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_idx = PTR_W'((int'(i_ptr) + k) % NUM_MASTERS);
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter with stall timeout and post-abort lockout.
module wb_arbiter import wb_pkg::*; #(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int DATA        = DEF_DATA,
    parameter int ADDR        = DEF_ADDR,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic        wb_clk,
    input  logic        rst_n,
    wb_arbiter_if.slave bus
);
    localparam int STRB  = DATA / 8;
    localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    arb_state_e             r_state, w_next;
    logic [NUM_MASTERS-1:0] r_grant, r_lock, w_req, w_pick;
    logic [PTR_W-1:0]       r_ptr, r_owner, w_pick_idx;
    logic [15:0]            r_wait, r_tcnt;
    logic                   w_own_cyc, w_own_stb, w_own_we, w_stall, w_tmo;
    logic [ADDR-1:0]        w_own_adr;
    logic [DATA-1:0]        w_own_dat;
    logic [STRB-1:0]        w_own_sel;

    // A master aborted by timeout stays out until it drops cyc once
    assign w_req = bus.m_cyc_i & ~r_lock;

    rr_pick #(.NUM_MASTERS(NUM_MASTERS), .PTR_W(PTR_W)) u_pick (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick)
    );

    // Convert the one-hot pick into an index
    always_comb begin
        w_pick_idx = '0;
        for (int k = 0; k < NUM_MASTERS; k++)
            if (w_pick[k]) w_pick_idx = PTR_W'(k);
    end

    // Select the current owner's request lines
    always_comb begin
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
        w_own_we  = 1'b0;
        w_own_adr = '0;
        w_own_dat = '0;
        w_own_sel = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (r_owner == PTR_W'(k)) begin
                w_own_cyc = bus.m_cyc_i[k];
                w_own_stb = bus.m_stb_i[k];
                w_own_we  = bus.m_we_i[k];
                w_own_adr = bus.m_adr_i[k*ADDR +: ADDR];
                w_own_dat = bus.m_dat_i[k*DATA +: DATA];
                w_own_sel = bus.m_sel_i[k*STRB +: STRB];
            end
        end
    end

    // Stalled strobe; timeout fires when this stall would bring the count to TIMEOUT
    assign w_stall = (r_state == ST_OWNED) && w_own_stb && !bus.s_ack_i && !bus.s_err_i;
    assign w_tmo   = w_stall && (({1'b0, r_wait} + 17'd1) >= 17'(TIMEOUT));

    // State register
    always_ff @(posedge wb_clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (|w_pick) w_next = ST_OWNED;
            ST_OWNED: begin
                if (!w_own_cyc)  w_next = ST_IDLE;
                else if (w_tmo)  w_next = ST_ABORT;
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    // Bus outputs: mirror owner to slave, route response back to owner only
    always_comb begin
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        bus.m_ack_o = '0;
        bus.m_err_o = '0;
        bus.m_dat_o = '0;
        bus.grant_o = '0;
        if (r_state == ST_OWNED) begin
            bus.s_cyc_o = w_own_cyc;
            bus.s_stb_o = w_own_stb;
            bus.s_we_o  = w_own_we;
            bus.s_adr_o = w_own_adr;
            bus.s_dat_o = w_own_dat;
            bus.s_sel_o = w_own_sel;
            bus.m_dat_o = bus.s_dat_i;
            bus.m_ack_o = r_grant & {NUM_MASTERS{bus.s_ack_i}};
            bus.m_err_o = r_grant & {NUM_MASTERS{bus.s_err_i}};
            bus.grant_o = r_grant;
        end else if (r_state == ST_ABORT) begin
            bus.m_err_o = r_grant;
        end
    end

    assign bus.timeout_cnt_o = r_tcnt;

    // Grant, pointer, wait counter, timeout statistics and lockout
    always_ff @(posedge wb_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_wait  <= '0;
            r_tcnt  <= '0;
            r_lock  <= '0;
        end else begin
            r_lock <= r_lock & bus.m_cyc_i;
            case (r_state)
                ST_IDLE: begin
                    r_wait <= '0;
                    if (|w_pick) begin
                        r_grant <= w_pick;
                        r_owner <= w_pick_idx;
                        r_ptr   <= PTR_W'(wrap_inc(int'(w_pick_idx), NUM_MASTERS));
                    end
                end
                ST_OWNED: begin
                    if (!w_own_cyc) begin
                        r_wait <= '0;
                    end else if (w_tmo) begin
                        r_wait <= '0;
                        r_lock <= (r_lock & bus.m_cyc_i) | r_grant;
                        if (r_tcnt != 16'hFFFF) r_tcnt <= r_tcnt + 16'd1;
                    end else if (w_stall) begin
                        r_wait <= r_wait + 16'd1;
                    end else begin
                        r_wait <= '0;
                    end
                end
                default: r_wait <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed scenarios followed by a randomized run against a behavioural model.
module tb_wb_arbiter;
    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic wb_clk = 1'b0;
    logic rst_n  = 1'b1;
    always #5 wb_clk = ~wb_clk;

    wb_arbiter_if #(.NUM_MASTERS(N), .DATA(DW), .ADDR(AW)) bus();

    wb_arbiter #(.NUM_MASTERS(N), .DATA(DW), .ADDR(AW), .TIMEOUT(TO)) dut (
        .wb_clk (wb_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // scenario bookkeeping
    int          acks;
    bit          drop [N];
    logic [1:0]  prev_g;
    int          zrun;
    logic [1:0]  seq_q [$];
    int          gap_q [$];
    logic [1:0]  exp_seq [4];

    // reference model
    int          own, ab, mptr, mw, mtc;
    bit          mlock [N];
    bit          nlock [N];
    bit          cy;
    logic [1:0]  e_g, e_ack, e_err;
    logic        e_cyc;
    logic [31:0] e_adr, e_dat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic step();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge wb_clk);
    endtask

    task automatic set_m(input int i, input bit c, input bit s, input bit w, input logic [31:0] a);
        bus.m_cyc_i[i]          = c;
        bus.m_stb_i[i]          = s;
        bus.m_we_i[i]           = w;
        bus.m_adr_i[i*AW +: AW] = a;
        bus.m_dat_i[i*DW +: DW] = 32'hD0D0_0000 | a;
        bus.m_sel_i[i*4 +: 4]   = 4'hF;
    endtask

    task automatic idle_inputs();
        bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0;
        bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0;
        bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_dat_i = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        smp();
        smp();
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        #2 rst_n = 1'b0;
        smp();
        chk("rst_grant", bus.grant_o, 0);
        chk("rst_s_cyc", bus.s_cyc_o, 0);
        chk("rst_s_stb", bus.s_stb_o, 0);
        chk("rst_tcnt",  bus.timeout_cnt_o, 0);
        chk("rst_ack",   bus.m_ack_o, 0);
        chk("rst_err",   bus.m_err_o, 0);
        rst_n = 1'b1;

        // single master write to 0x10, slave acks in the third owned cycle
        step(); set_m(0, 1, 1, 1, 32'h10);
        smp();  chk("s1_latency", bus.grant_o, 0);
        acks = 0;
        step(); smp();
        chk("s1_grant", bus.grant_o, 2'b01);
        chk("s1_adr",   bus.s_adr_o, 32'h10);
        chk("s1_cyc",   bus.s_cyc_o, 1);
        chk("s1_we",    bus.s_we_o, 1);
        chk("s1_dat",   bus.s_dat_o, 32'hD0D0_0010);
        acks += bus.m_ack_o[0];
        step(); smp(); acks += bus.m_ack_o[0];
        step(); bus.s_ack_i = 1'b1;
        smp();  chk("s1_ack", bus.m_ack_o, 2'b01); acks += bus.m_ack_o[0];
        step(); bus.s_ack_i = 1'b0; set_m(0, 0, 0, 0, 0);
        smp();  chk("s1_cyc_drop", bus.s_cyc_o, 0); acks += bus.m_ack_o[0];
        step(); smp();
        chk("s1_idle", bus.grant_o, 0); acks += bus.m_ack_o[0];
        chk("s1_ack_once", acks, 1);

        // fairness: both masters request continuously, 1-cycle acks
        do_reset();
        for (int i = 0; i < N; i++) drop[i] = 1'b0;
        prev_g = '0; zrun = 0;
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
        for (int c = 0; c < 24 && seq_q.size() < 4; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (drop[i]) begin set_m(i, 0, 0, 0, 0); drop[i] = 1'b0; end
                else set_m(i, 1, 1, 0, 32'h100 + i);
            end
            bus.s_ack_i = |(bus.grant_o & bus.m_cyc_i);
            smp();
            for (int i = 0; i < N; i++) if (bus.m_ack_o[i]) drop[i] = 1'b1;
            if (bus.grant_o != 0 && prev_g == 0) begin
                seq_q.push_back(bus.grant_o);
                gap_q.push_back(zrun);
            end
            zrun   = (bus.grant_o == 0) ? zrun + 1 : 0;
            prev_g = bus.grant_o;
        end
        chk("s2_grants", seq_q.size(), 4);
        for (int k = 0; k < seq_q.size(); k++) begin
            chk($sformatf("s2_order%0d", k), seq_q[k], exp_seq[k]);
            if (k > 0) chk($sformatf("s2_gap%0d", k), gap_q[k], 1);
        end

        // timeout: slave never acks m0, m1 waiting
        do_reset();
        step(); set_m(0, 1, 1, 0, 32'h40); set_m(1, 1, 1, 0, 32'h80);
        smp();  chk("s3_req_idle", bus.grant_o, 0);
        for (int k = 1; k <= 4; k++) begin
            step(); smp();
            chk($sformatf("s3_noerr%0d", k), bus.m_err_o, 0);
            chk($sformatf("s3_own%0d", k), bus.grant_o, 2'b01);
        end
        step(); smp();
        chk("s3_err",       bus.m_err_o, 2'b01);
        chk("s3_abort_cyc", bus.s_cyc_o, 0);
        chk("s3_abort_gnt", bus.grant_o, 0);
        step(); smp();
        chk("s3_tcnt",      bus.timeout_cnt_o, 1);
        chk("s3_err_once",  bus.m_err_o, 0);
        step(); bus.s_ack_i = 1'b1;
        smp();  chk("s3_m1_grant", bus.grant_o, 2'b10);
        chk("s3_m1_ack", bus.m_ack_o, 2'b10);
        step(); bus.s_ack_i = 1'b0; set_m(1, 0, 0, 0, 0);
        smp();
        step(); smp();
        step(); smp(); chk("s3_lockout", bus.grant_o, 0);
        step(); set_m(0, 0, 0, 0, 0);
        smp();
        step(); set_m(0, 1, 1, 0, 32'h44);
        smp();  chk("s3_relock_idle", bus.grant_o, 0);
        step(); smp(); chk("s3_reown", bus.grant_o, 2'b01);

        // ack on the cycle the counter would reach TIMEOUT
        for (int k = 0; k < 2; k++) begin
            step(); smp(); chk($sformatf("s4_wait%0d", k), bus.m_err_o, 0);
        end
        step(); bus.s_ack_i = 1'b1;
        smp();  chk("s4_ack", bus.m_ack_o, 2'b01);
        chk("s4_err", bus.m_err_o, 0);
        step(); bus.s_ack_i = 1'b0; set_m(0, 0, 0, 0, 0);
        smp();  chk("s4_no_abort", bus.grant_o, 2'b01);
        chk("s4_err_after", bus.m_err_o, 0);
        step(); smp();
        chk("s4_tcnt", bus.timeout_cnt_o, 1);
        chk("s4_idle", bus.grant_o, 0);

        // reset in the middle of an owned transfer
        step(); set_m(1, 1, 1, 1, 32'h20);
        smp();
        step(); smp();
        chk("s5_grant", bus.grant_o, 2'b10);
        chk("s5_cyc",   bus.s_cyc_o, 1);
        #1 bus.s_ack_i = 1'b1;
        #1 chk("s5_ack_pre", bus.m_ack_o, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("s5_cyc_async", bus.s_cyc_o, 0);
        chk("s5_ack_async", bus.m_ack_o, 0);
        chk("s5_err_async", bus.m_err_o, 0);
        chk("s5_gnt_async", bus.grant_o, 0);
        chk("s5_tcnt_async", bus.timeout_cnt_o, 0);
        bus.s_ack_i = 1'b0;
        set_m(0, 1, 1, 0, 32'h30);
        smp();
        rst_n = 1'b1;
        step(); smp();
        chk("s5_first", bus.grant_o, 2'b01);

        // randomized traffic against the reference model
        do_reset();
        own = -1; ab = -1; mptr = 0; mw = 0; mtc = 0;
        for (int i = 0; i < N; i++) mlock[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                cy = bus.m_cyc_i[i];
                cy = cy ? ($urandom_range(7) != 0) : ($urandom_range(2) == 0);
                set_m(i, cy, cy && ($urandom_range(3) != 0), 1'($urandom_range(1)), $urandom);
            end
            bus.s_ack_i = ($urandom_range(3) == 0);
            bus.s_err_i = ($urandom_range(15) == 0);
            bus.s_dat_i = $urandom;
            smp();

            e_g = '0; e_ack = '0; e_err = '0; e_cyc = 1'b0; e_adr = '0; e_dat = '0;
            if (own >= 0) begin
                e_g[own]   = 1'b1;
                e_cyc      = bus.m_cyc_i[own];
                e_adr      = bus.m_adr_i[own*AW +: AW];
                e_ack[own] = bus.s_ack_i;
                e_err[own] = bus.s_err_i;
                e_dat      = bus.s_dat_i;
            end else if (ab >= 0) begin
                e_err[ab] = 1'b1;
            end
            chk("rnd_grant", bus.grant_o, e_g);
            chk("rnd_cyc",   bus.s_cyc_o, e_cyc);
            chk("rnd_adr",   bus.s_adr_o, e_adr);
            chk("rnd_ack",   bus.m_ack_o, e_ack);
            chk("rnd_err",   bus.m_err_o, e_err);
            chk("rnd_dat",   bus.m_dat_o, e_dat);
            chk("rnd_tcnt",  bus.timeout_cnt_o, mtc);

            for (int i = 0; i < N; i++) nlock[i] = mlock[i] && bus.m_cyc_i[i];
            if (own >= 0) begin
                if (!bus.m_cyc_i[own]) begin
                    own = -1; mw = 0;
                end else if (bus.m_stb_i[own] && !bus.s_ack_i && !bus.s_err_i) begin
                    if (mw + 1 >= TO) begin
                        ab = own; nlock[own] = 1'b1; own = -1; mw = 0;
                        if (mtc < 65535) mtc++;
                    end else mw++;
                end else mw = 0;
            end else if (ab >= 0) begin
                ab = -1;
            end else begin
                mw = 0;
                for (int k = 0; k < N; k++) begin
                    if (own < 0 && bus.m_cyc_i[(mptr + k) % N] && !mlock[(mptr + k) % N]) begin
                        own  = (mptr + k) % N;
                        mptr = (own + 1) % N;
                    end
                end
            end
            for (int i = 0; i < N; i++) mlock[i] = nlock[i];
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 2, SHALL set the number of Wishbone requesters (2..8).
REQ-002 Parameter DATA, default 32, SHALL set the data width; STRB is derived as DATA/8.
REQ-003 Parameter ADDR, default 32, SHALL set the address width.
REQ-004 Parameter TIMEOUT, default 255, SHALL set the number of cycles an unacknowledged strobe is allowed to wait (1..65535).
REQ-005 Clocking SHALL be fixed as: one clock, wb_clk; reset rst_n is asynchronous and active-low.
REQ-006 Port wb_clk, input, 1, sole clock.
REQ-007 Port rst_n, input, 1, asynchronous active-low reset.
REQ-008 Ports m_cyc_i, m_stb_i and m_we_i SHALL be inputs, NUM_MASTERS wide each, carrying the per-master cycle, strobe and write-enable signals.
REQ-009 Ports m_adr_i (NUM_MASTERS*ADDR), m_dat_i (NUM_MASTERS*DATA) and m_sel_i (NUM_MASTERS*STRB) SHALL be inputs, flattened with master 0 in the LSBs.
REQ-010 Ports m_ack_o and m_err_o SHALL be outputs, NUM_MASTERS wide each, carrying the per-master acknowledge and error.
REQ-011 Port m_dat_o SHALL be an output, DATA wide, carrying the shared read data to all masters.
REQ-012 Ports s_cyc_o, s_stb_o and s_we_o (1 bit each), s_adr_o (ADDR), s_dat_o (DATA) and s_sel_o (STRB) SHALL be outputs toward the slave.
REQ-013 Ports s_ack_i, s_err_i (1 bit each) and s_dat_i (DATA) SHALL be inputs from the slave.
REQ-014 Port grant_o SHALL be an output, NUM_MASTERS wide, one-hot, showing the current owner and all-zero when idle.
REQ-015 Port timeout_cnt_o SHALL be an output, 16 bits wide, counting saturated timeout events.

Function
REQ-016 The FSM SHALL have three states: IDLE, OWNED and ABORT.
REQ-017 In IDLE with any m_cyc_i high, the block SHALL register a grant to the first requester at or after rr_ptr (round-robin, wrapping modulo NUM_MASTERS) and SHALL enter OWNED on the next edge.
REQ-018 rr_ptr SHALL be set to the granted index + 1, wrapping to 0 after NUM_MASTERS-1, at each grant.
REQ-019 In OWNED, s_cyc/stb/we/adr/dat/sel SHALL combinationally mirror the owner's inputs.
REQ-020 In OWNED, s_ack_i, s_err_i and s_dat_i SHALL be routed only to the owner; non-owners SHALL see ack=0 and err=0.
REQ-021 In IDLE and ABORT, s_cyc_o and s_stb_o SHALL be 0, and all m_ack_o and m_err_o SHALL be 0 except as REQ-025 specifies.
REQ-022 OWNED SHALL return to IDLE on the edge after the owner deasserts m_cyc_i, giving at least one idle cycle between owners.
REQ-023 A grant SHALL never be revoked while the owner holds m_cyc_i, except by the timeout.
REQ-024 The wait counter SHALL increment each OWNED cycle in which s_stb_o is high and both s_ack_i and s_err_i are low; it SHALL clear on ack, on err, or when the strobe drops.
REQ-025 When the wait counter reaches TIMEOUT, the block SHALL enter ABORT for exactly one cycle, pulse m_err_o of the owner in that cycle, and increment timeout_cnt_o (saturating at 0xFFFF).
REQ-026 From ABORT, the block SHALL go to IDLE, and the aborted master SHALL get no grant until it has deasserted m_cyc_i for at least one cycle.
REQ-027 If s_ack_i arrives in the same cycle the counter reaches TIMEOUT, the ack SHALL win and no ABORT SHALL occur.
REQ-028 If the owner drops m_cyc_i while its strobe is pending, the block SHALL go to IDLE and clear the wait counter.
REQ-029 A new request SHALL see grant latency of 1 cycle from IDLE.

Reset
REQ-030 While rst_n is low, the block SHALL be in IDLE with grant_o=0, rr_ptr=0, wait counter=0, timeout_cnt_o=0 and abort-lockout cleared, and all slave-side and master-side outputs 0.
REQ-031 Assertion of rst_n during OWNED SHALL drop s_cyc_o asynchronously with no ack or err issued.

Structure
REQ-032 The shared package wb_pkg SHALL hold the FSM state encoding, the CTI constants and the default widths.
REQ-033 The round-robin priority picker SHALL be the sub-module rr_pick (requests and pointer in, one-hot grant out, combinational).

Verification
REQ-034 The bench SHALL cover single-master use: m0 cyc/stb with write to 0x10, slave acks after 3 cycles -> s_adr_o=0x10, m_ack_o[0] pulses once, grant_o=01, then IDLE.
REQ-035 The bench SHALL cover fairness: m0 and m1 request continuously with 1-cycle acks -> grants alternate 01,10,01,10 with one idle cycle between.
REQ-036 The bench SHALL cover timeout: TIMEOUT=4, slave never acks -> m_err_o pulses on the 5th OWNED cycle, timeout_cnt_o=1, and m1 is granted before m0 can re-own.
REQ-037 The bench SHALL cover the ack/timeout tie: ack on the cycle the counter hits TIMEOUT -> m_ack_o=1, m_err_o=0, timeout_cnt_o unchanged.
REQ-038 The bench SHALL cover reset mid-transfer: rst_n low during OWNED -> s_cyc_o=0 with no clock edge, and after release the first grant goes to m0.
